bram_boot_loader: RTL and testbench
===================================

// Module: bram_boot_loader
// PURPOSE
// Streams program/data words from a host-side valid/ready source into up to NUM_CH BRAM write ports
// (instruction BRAM, data BRAM, ...), then releases the core by dropping cpu_stall.
// Sits between the host/bench and the bram32 write ports; the top level muxes each BRAM write port
// between loader and core using loader_owns[ch].
// PARAMETERS
// DATA_WIDTH  32  word width; byte_enb width = DATA_WIDTH/8
// ADDR_WIDTH  12  byte address width of each BRAM write port
// NUM_CH      2   number of BRAM channels (ch 0 = instruction, ch 1 = data)
// CH_W        1   ch_sel width = max(1, clog2(NUM_CH))
// PORTS
// clk          in   1              system clock, all state on rising edge
// rst          in   1              asynchronous reset, active-low
// start        in   1              1-cycle pulse: begin loading channel ch_sel (accepted in IDLE only)
// ch_sel       in   CH_W           target channel for start
// base_addr    in   ADDR_WIDTH     first byte address; low log2(DATA_WIDTH/8) bits ignored (aligned)
// word_count   in   ADDR_WIDTH+1   number of words to load (0 allowed)
// run          in   1              1-cycle pulse: release core (accepted in IDLE only)
// s_valid      in   1              source word valid
// s_data       in   DATA_WIDTH     source word
// s_ready      out  1              loader accepts word this cycle
// w_addr       out  ADDR_WIDTH     shared BRAM write address, word aligned
// w_dat        out  DATA_WIDTH     shared BRAM write data
// w_enb        out  NUM_CH         one-hot per-channel write enable
// byte_enb     out  DATA_WIDTH/8   all ones whenever any w_enb bit is set, else zero
// loader_owns  out  NUM_CH         bit ch high: loader drives that BRAM port, core must not write
// cpu_stall    out  1              high = core PC stalled
// busy         out  1              high in LOAD
// done         out  1              1-cycle pulse: channel load completed
// error        out  1              sticky; address overflow detected, cleared by next accepted start
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; cpu_stall=1; loader_owns=all ones; w_enb=0; byte_enb=0;
//   w_addr=0; w_dat=0; s_ready=0; busy=0; done=0; error=0; counters=0.
// - FSM: IDLE, LOAD, FLUSH.
//   IDLE:  start with word_count!=0 -> LOAD; latch ch, addr=aligned base_addr, remaining=word_count;
//          clear error; set cpu_stall=1, loader_owns=all ones.
//          start with word_count==0 -> stay IDLE, done pulses next cycle, no writes.
//          run (and no start) -> cpu_stall=0, loader_owns=0 from next cycle.
//          start and run in same cycle: start wins, run ignored.
//   LOAD:  s_ready=1 (combinational from state). Beat = s_valid & s_ready.
//          Each beat registers one write: next cycle w_enb[ch]=1, w_addr=addr, w_dat=s_data,
//          byte_enb=all ones. Write latency: exactly 1 cycle after the beat.
//          addr += DATA_WIDTH/8, remaining -= 1 per beat.
//          Last beat (remaining==1) -> FLUSH.
//          Overflow: a beat whose addr is the last word of the space and remaining>1 -> still
//          writes that word, then error=1, -> FLUSH (no wrap to 0, ever).
//          start/run ignored in LOAD. s_valid gaps simply stall; no timeout.
//   FLUSH: final write visible on w_enb this cycle; s_ready=0; done=1 for this cycle; -> IDLE.
// - w_enb is zero on every cycle without a preceding beat; at most one channel bit set.
// - Back-to-back beats give back-to-back writes (1 word/cycle throughput).
// - Reset mid-LOAD aborts immediately: no further writes, outputs as reset; partially written
//   BRAM contents are left unchanged.
// - cpu_stall only falls via run; any accepted start raises it again.
// TESTING
// 1 Reset -> cpu_stall=1, loader_owns=2'b11, w_enb=0, s_ready=0, error=0.
// 2 start ch=0 base=0x000 count=7, 7 back-to-back words 0x00A00293..: w_enb=2'b01 on 7 consecutive
//   cycles, w_addr 0x000..0x018 step 4, one cycle after each beat; done pulse once; busy low after.
// 3 start ch=1 base=0x002 count=4, s_valid toggled 1,0,1,0..: writes at 0x000,0x004,0x008,0x00C
//   only on beat+1 cycles, w_enb=2'b10; then run -> cpu_stall=0, loader_owns=0 next cycle.
// 4 start ch=0 base=0xFF8 count=4: writes 0xFF8, 0xFFC only, error=1, done pulses, no write to
//   0x000; next start with count=1 clears error.
// 5 start count=0 -> no w_enb, done one cycle later; start and run same cycle -> cpu_stall stays 1.
// 6 rst low during beat 3 of count=7 load -> w_enb=0 asynchronously, state IDLE, cpu_stall=1;
//   after release a fresh load of 2 words writes normally.

Source files
------------

// File: rtl/bram_boot_loader_if.sv
// Source stream and shared BRAM write bus used by the boot loader.
// The loader uses the master view; the host/bench side uses the slave view.
interface bram_boot_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CH     = 2
);
  logic                    s_valid;
  logic [DATA_WIDTH-1:0]   s_data;
  logic                    s_ready;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_dat;
  logic [NUM_CH-1:0]       w_enb;
  logic [DATA_WIDTH/8-1:0] byte_enb;

  modport master (
    input  s_valid, s_data,
    output s_ready, w_addr, w_dat, w_enb, byte_enb
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, w_addr, w_dat, w_enb, byte_enb
  );
endinterface

// File: rtl/bram_boot_loader.sv
// BRAM boot loader: streams words from a valid/ready source into one of
// NUM_CH BRAM write ports, then releases the core by dropping cpu_stall.
// Writes appear on the shared bus exactly one cycle after each accepted beat.
module bram_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [CH_W-1:0]       i_ch_sel,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  input  logic                  i_run,
  bram_boot_loader_if.master    bus,
  output logic [NUM_CH-1:0]     o_loader_owns,
  output logic                  o_cpu_stall,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CH_W-1:0]         r_ch;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH:0]     r_remaining;
  logic [NUM_CH-1:0]       r_wenb;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [DATA_WIDTH-1:0]   r_wdat;
  logic [NUM_CH-1:0]       r_owns;
  logic                    r_cpu_stall;
  logic                    r_error;
  logic                    r_zero_done;

  logic w_beat;
  logic w_last_word;
  logic w_overflow;
  logic w_start_ok;
  logic w_run_ok;

  // Handshake qualifiers; start takes priority over run in the same cycle.
  assign w_beat      = bus.s_valid && (r_state == LOAD);
  assign w_last_word = &r_addr[ADDR_WIDTH-1:LSB];
  assign w_overflow  = w_beat && w_last_word && (r_remaining > CNT_ONE);
  assign w_start_ok  = (r_state == IDLE) && i_start;
  assign w_run_ok    = (r_state == IDLE) && i_run && !i_start;

  assign bus.s_ready  = (r_state == LOAD);
  assign bus.w_addr   = r_waddr;
  assign bus.w_dat    = r_wdat;
  assign bus.w_enb    = r_wenb;
  assign bus.byte_enb = (|r_wenb) ? '1 : '0;

  assign o_loader_owns = r_owns;
  assign o_cpu_stall   = r_cpu_stall;
  assign o_busy        = (r_state == LOAD);
  assign o_done        = (r_state == FLUSH) || r_zero_done;
  assign o_error       = r_error;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the last beat or an address overflow ends the load.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start && (i_word_count != '0)) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        if (w_beat && ((r_remaining == CNT_ONE) || w_last_word)) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: registered write bus, load counters, core release and error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ch        <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_wenb      <= '0;
      r_waddr     <= '0;
      r_wdat      <= '0;
      r_owns      <= '1;
      r_cpu_stall <= 1'b1;
      r_error     <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_wenb      <= '0;
      r_zero_done <= 1'b0;
      if (w_beat) begin
        r_wenb      <= NUM_CH'(1) << r_ch;
        r_waddr     <= r_addr;
        r_wdat      <= bus.s_data;
        r_addr      <= r_addr + ADDR_STEP;
        r_remaining <= r_remaining - CNT_ONE;
        if (w_overflow) begin
          r_error <= 1'b1;
        end
      end
      if (w_start_ok) begin
        r_error     <= 1'b0;
        r_cpu_stall <= 1'b1;
        r_owns      <= '1;
        if (i_word_count == '0) begin
          r_zero_done <= 1'b1;
        end else begin
          r_ch        <= i_ch_sel;
          r_addr      <= i_base_addr & ALIGN_MASK;
          r_remaining <= i_word_count;
        end
      end else if (w_run_ok) begin
        r_cpu_stall <= 1'b0;
        r_owns      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bram_boot_loader.sv
// Directed testbench for bram_boot_loader: inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_bram_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [0:0]  ch_sel;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic        run;
  logic [1:0]  loader_owns;
  logic        cpu_stall;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  bram_boot_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_CH(2)) bus ();

  bram_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_CH(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_ch_sel      (ch_sel),
    .i_base_addr   (base_addr),
    .i_word_count  (word_count),
    .i_run         (run),
    .bus           (bus),
    .o_loader_owns (loader_owns),
    .o_cpu_stall   (cpu_stall),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expectWrite(input string tag, input logic [1:0] enb,
                             input logic [11:0] addr, input logic [31:0] dat);
    checkOutput({tag, " w_enb"}, 32'(bus.w_enb), 32'(enb));
    checkOutput({tag, " byte_enb"}, 32'(bus.byte_enb), 32'hF);
    checkOutput({tag, " w_addr"}, 32'(bus.w_addr), 32'(addr));
    checkOutput({tag, " w_dat"}, bus.w_dat, dat);
  endtask

  // Drives a one-cycle start and/or run pulse from a falling edge; returns on the next falling edge.
  task automatic applyStimulus(input logic st, input logic rn, input logic [0:0] ch,
                               input logic [11:0] base, input logic [12:0] cnt);
    start      = st;
    run        = rn;
    ch_sel     = ch;
    base_addr  = base;
    word_count = cnt;
    @(negedge clk);
    start = 1'b0;
    run   = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    run         = 1'b0;
    ch_sel      = '0;
    base_addr   = '0;
    word_count  = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst cpu_stall", 32'(cpu_stall), 32'd1);
    checkOutput("rst loader_owns", 32'(loader_owns), 32'h3);
    checkOutput("rst w_enb", 32'(bus.w_enb), 32'h0);
    checkOutput("rst byte_enb", 32'(bus.byte_enb), 32'h0);
    checkOutput("rst s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("rst error", 32'(error), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);

    // Seven back-to-back words into channel 0
    $display("[TB] back-to-back load ch0");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 13'd7);
    checkOutput("b2b busy", 32'(busy), 32'd1);
    checkOutput("b2b s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("b2b no early write", 32'(bus.w_enb), 32'h0);
    for (int i = 0; i < 7; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h00A00293 + 32'(i) * 32'h00100000;
      @(negedge clk);
      expectWrite("b2b", 2'b01, 12'(4 * i), 32'h00A00293 + 32'(i) * 32'h00100000);
      checkOutput("b2b done", 32'(done), (i == 6) ? 32'd1 : 32'd0);
    end
    checkOutput("b2b flush s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b idle w_enb", 32'(bus.w_enb), 32'h0);
    checkOutput("b2b idle busy", 32'(busy), 32'd0);
    checkOutput("b2b idle done", 32'(done), 32'd0);

    // Gapped source into channel 1, unaligned base
    $display("[TB] gapped load ch1");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h002, 13'd4);
    for (int j = 0; j < 8; j++) begin
      bus.s_valid = (j % 2 == 0);
      bus.s_data  = 32'hD0000000 + 32'(j);
      @(negedge clk);
      if (j % 2 == 0) begin
        expectWrite("gap", 2'b10, 12'(2 * j), 32'hD0000000 + 32'(j));
      end else begin
        checkOutput("gap idle w_enb", 32'(bus.w_enb), 32'h0);
      end
      if (j == 6) checkOutput("gap done", 32'(done), 32'd1);
    end
    checkOutput("gap busy", 32'(busy), 32'd0);
    checkOutput("gap stall before run", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 13'd0);
    checkOutput("run cpu_stall", 32'(cpu_stall), 32'd0);
    checkOutput("run loader_owns", 32'(loader_owns), 32'h0);

    // Address overflow at the top of the space
    $display("[TB] overflow load");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'hFF8, 13'd4);
    checkOutput("ovf stall raised", 32'(cpu_stall), 32'd1);
    checkOutput("ovf owns raised", 32'(loader_owns), 32'h3);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h11111111;
    @(negedge clk);
    expectWrite("ovf w0", 2'b01, 12'hFF8, 32'h11111111);
    checkOutput("ovf w0 error", 32'(error), 32'd0);
    bus.s_data = 32'h22222222;
    @(negedge clk);
    expectWrite("ovf w1", 2'b01, 12'hFFC, 32'h22222222);
    checkOutput("ovf error", 32'(error), 32'd1);
    checkOutput("ovf done", 32'(done), 32'd1);
    checkOutput("ovf s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_data = 32'h33333333;
    @(negedge clk);
    checkOutput("ovf no wrap w_enb", 32'(bus.w_enb), 32'h0);
    checkOutput("ovf error sticky", 32'(error), 32'd1);
    checkOutput("ovf busy", 32'(busy), 32'd0);
    bus.s_valid = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h100, 13'd1);
    checkOutput("ovf error cleared", 32'(error), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hCAFEF00D;
    @(negedge clk);
    expectWrite("one", 2'b10, 12'h100, 32'hCAFEF00D);
    checkOutput("one done", 32'(done), 32'd1);
    bus.s_valid = 1'b0;
    @(negedge clk);
    checkOutput("one idle w_enb", 32'(bus.w_enb), 32'h0);

    // Zero-length load and start/run collision
    $display("[TB] zero count and start/run collision");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h040, 13'd0);
    checkOutput("zero done", 32'(done), 32'd1);
    checkOutput("zero busy", 32'(busy), 32'd0);
    checkOutput("zero w_enb", 32'(bus.w_enb), 32'h0);
    @(negedge clk);
    checkOutput("zero done once", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 13'd0);
    checkOutput("run2 cpu_stall", 32'(cpu_stall), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000, 13'd0);
    checkOutput("collide cpu_stall", 32'(cpu_stall), 32'd1);
    checkOutput("collide owns", 32'(loader_owns), 32'h3);
    checkOutput("collide done", 32'(done), 32'd1);

    // Asynchronous reset in the middle of a load
    $display("[TB] reset mid-load");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h040, 13'd7);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hAAAA0000;
    @(negedge clk);
    expectWrite("mid w0", 2'b01, 12'h040, 32'hAAAA0000);
    bus.s_data = 32'hAAAA0001;
    @(negedge clk);
    expectWrite("mid w1", 2'b01, 12'h044, 32'hAAAA0001);
    bus.s_data = 32'hAAAA0002;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst w_enb", 32'(bus.w_enb), 32'h0);
    checkOutput("mid rst busy", 32'(busy), 32'd0);
    checkOutput("mid rst s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("mid rst cpu_stall", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    checkOutput("mid rst hold w_enb", 32'(bus.w_enb), 32'h0);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post rst busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h200, 13'd2);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hBEEF0000;
    @(negedge clk);
    expectWrite("post w0", 2'b10, 12'h200, 32'hBEEF0000);
    bus.s_data = 32'hBEEF0001;
    @(negedge clk);
    expectWrite("post w1", 2'b10, 12'h204, 32'hBEEF0001);
    checkOutput("post done", 32'(done), 32'd1);
    bus.s_valid = 1'b0;
    @(negedge clk);
    checkOutput("post idle w_enb", 32'(bus.w_enb), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
